// File: rtl/aes_rkey_ctrl.sv
// AES-128 round-key store sequencer: runs key expansion into the store, then streams
// the NR+1 round keys to the cipher core in forward or reverse order, one block at a time.
module aes_rkey_ctrl #(
    parameter int NR = 10,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_load,
    output logic          kx_start,
    input  logic          kx_valid,
    output logic          kx_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          keys_valid,
    input  logic          blk_start,
    input  logic          blk_dec,
    output logic          blk_ready,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_addr,
    output logic          rd_last,
    output logic          blk_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KICK   = 3'd1,
        EXPAND = 3'd2,
        READY  = 3'd3,
        RUN    = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NR);
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic          dec;
    logic          pend;
    logic          rd_valid_q;
    logic          blk_done_q;
    logic          keys_valid_q;

    logic          wr_hs;
    logic          rd_hs;
    logic          rd_end;
    logic          blk_acc;

    assign wr_hs   = (state == EXPAND) & kx_valid;
    assign rd_hs   = (state == RUN) & rd_valid_q & rd_ready;
    assign rd_end  = dec ? (rcnt == '0) : (rcnt == LAST);
    assign blk_acc = (state == READY) & blk_start & ~key_load;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (key_load) state_nxt = KICK;
            end
            KICK: begin
                state_nxt = key_load ? KICK : EXPAND;
            end
            EXPAND: begin
                if (key_load)
                    state_nxt = KICK;
                else if (wr_hs && (wcnt == LAST))
                    state_nxt = READY;
            end
            READY: begin
                if (key_load)
                    state_nxt = KICK;
                else if (blk_start)
                    state_nxt = RUN;
            end
            RUN: begin
                // a reload requested mid-block is only honoured once the block drains
                if (rd_hs && rd_end)
                    state_nxt = (pend || key_load) ? KICK : READY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt         <= '0;
            keys_valid_q <= 1'b0;
            pend         <= 1'b0;
        end else begin
            if (state_nxt == KICK)
                wcnt <= '0;
            else if (wr_hs && (wcnt != LAST))
                wcnt <= wcnt + ONE;

            if (state_nxt == KICK)
                keys_valid_q <= 1'b0;
            else if (wr_hs && (wcnt == LAST) && !key_load)
                keys_valid_q <= 1'b1;

            if (state_nxt == KICK)
                pend <= 1'b0;
            else if ((state == RUN) && key_load)
                pend <= 1'b1;
        end
    end

    // read side: rd_addr is the read counter itself, so it holds naturally while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt       <= '0;
            dec        <= 1'b0;
            rd_valid_q <= 1'b0;
            blk_done_q <= 1'b0;
        end else begin
            blk_done_q <= rd_hs & rd_end;
            if (blk_acc) begin
                dec        <= blk_dec;
                rcnt       <= blk_dec ? LAST : '0;
                rd_valid_q <= 1'b1;
            end else if (rd_hs) begin
                if (rd_end)
                    rd_valid_q <= 1'b0;
                else
                    rcnt <= dec ? (rcnt - ONE) : (rcnt + ONE);
            end
        end
    end

    assign kx_start   = (state == KICK);
    assign kx_ready   = (state == EXPAND);
    assign wr_en      = wr_hs;
    assign wr_addr    = wcnt;
    assign keys_valid = keys_valid_q;
    assign blk_ready  = (state == READY) & ~key_load;
    assign rd_valid   = rd_valid_q;
    assign rd_addr    = rcnt;
    assign rd_last    = rd_valid_q & rd_end;
    assign blk_done   = blk_done_q;

endmodule

// File: tb/tb_aes_rkey_ctrl.sv
// Randomized bench for aes_rkey_ctrl: transaction-level expectations for key writes,
// round-key read order, reload serialisation and reset behaviour.
module tb_aes_rkey_ctrl;
    localparam int NR = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_load = 1'b0;
    logic          kx_valid = 1'b0;
    logic          blk_start = 1'b0;
    logic          blk_dec = 1'b0;
    logic          rd_ready = 1'b0;
    logic          kx_start, kx_ready, wr_en, keys_valid, blk_ready;
    logic          rd_valid, rd_last, blk_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [15:0]   all_out;

    int vec = 0;
    int errs = 0;

    aes_rkey_ctrl #(.NR(NR), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load),
        .kx_start(kx_start), .kx_valid(kx_valid), .kx_ready(kx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .keys_valid(keys_valid),
        .blk_start(blk_start), .blk_dec(blk_dec), .blk_ready(blk_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_last(rd_last), .blk_done(blk_done)
    );

    assign all_out = {kx_start, kx_ready, wr_en, wr_addr, keys_valid, blk_ready,
                      rd_valid, rd_addr, rd_last, blk_done};

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        key_load = 1'b1;
        repeat (3) step;
        smp;
        vec++;
        if (all_out !== 16'h0) begin
            errs++;
            $display("FAIL reset_outputs got %h exp 0000", all_out);
        end
        step;
        rst_n = 1'b1;
        key_load = 1'b0;
        smp;
        vec++;
        if (all_out !== 16'h0) begin
            errs++;
            $display("FAIL idle_after_reset got %h exp 0000", all_out);
        end
    endtask

    // expects writes 0..NR in order; optional abort when abort_at keys have been written
    task automatic do_expand(input int pct, input int abort_at, input bit kicked);
        int  w = 0;
        int  budget = 400;
        bit  aborted = 1'b0;
        if (!kicked) begin
            step;
            key_load = 1'b1;
            kx_valid = 1'b0;
            smp;
            step;
            key_load = 1'b0;
            smp;
            vec++;
            if (kx_start !== 1'b1 || keys_valid !== 1'b0 || kx_ready !== 1'b0) begin
                errs++;
                $display("FAIL kick got kx_start=%b keys_valid=%b kx_ready=%b exp 1 0 0",
                         kx_start, keys_valid, kx_ready);
            end
        end
        while (w <= NR && budget > 0) begin
            budget--;
            step;
            blk_start = 1'($urandom);
            blk_dec   = 1'($urandom);
            rd_ready  = 1'($urandom);
            if (!aborted && abort_at >= 0 && w == abort_at) begin
                key_load = 1'b1;
                kx_valid = 1'b0;
            end else begin
                key_load = 1'b0;
                kx_valid = ($urandom_range(99) < pct);
            end
            smp;
            vec++;
            if (kx_start !== 1'b0 || kx_ready !== 1'b1 || wr_en !== kx_valid ||
                keys_valid !== 1'b0 || blk_ready !== 1'b0 || rd_valid !== 1'b0) begin
                errs++;
                $display("FAIL expand_ctl w=%0d got start=%b rdy=%b wr_en=%b kv=%b br=%b rv=%b exp 0 1 %b 0 0 0",
                         w, kx_start, kx_ready, wr_en, keys_valid, blk_ready, rd_valid, kx_valid);
            end
            if (key_load) begin
                step;
                key_load = 1'b0;
                kx_valid = 1'b0;
                smp;
                vec++;
                if (kx_start !== 1'b1 || keys_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL abort_kick got kx_start=%b keys_valid=%b exp 1 0",
                             kx_start, keys_valid);
                end
                aborted = 1'b1;
                w = 0;
            end else if (wr_en === 1'b1) begin
                vec++;
                if (wr_addr !== AW'(w)) begin
                    errs++;
                    $display("FAIL wr_addr got %0d exp %0d", wr_addr, w);
                end
                w++;
            end
        end
        if (budget == 0) begin
            vec++;
            errs++;
            $display("FAIL expand_timeout got %0d writes exp %0d", w, NR + 1);
        end
        step;
        key_load  = 1'b0;
        blk_start = 1'b0;
        rd_ready  = 1'b0;
        kx_valid  = 1'b1;
        smp;
        vec++;
        if (keys_valid !== 1'b1 || kx_ready !== 1'b0 || wr_en !== 1'b0 || blk_ready !== 1'b1) begin
            errs++;
            $display("FAIL expand_done got kv=%b kx_ready=%b wr_en=%b blk_ready=%b exp 1 0 0 1",
                     keys_valid, kx_ready, wr_en, blk_ready);
        end
    endtask

    // one block; key_load pulses when beat count equals kl_beat or kl_beat+2
    task automatic do_block(input bit dec, input int pct, input int kl_beat);
        int b = 0;
        int budget = 400;
        int exp_a;
        bit pend = 1'b0;
        step;
        kx_valid  = 1'b0;
        key_load  = 1'b0;
        blk_start = 1'b1;
        blk_dec   = dec;
        rd_ready  = 1'b1;
        smp;
        vec++;
        if (blk_ready !== 1'b1 || rd_valid !== 1'b0 || keys_valid !== 1'b1) begin
            errs++;
            $display("FAIL blk_accept got blk_ready=%b rd_valid=%b keys_valid=%b exp 1 0 1",
                     blk_ready, rd_valid, keys_valid);
        end
        while (b <= NR && budget > 0) begin
            budget--;
            step;
            blk_start = 1'($urandom);
            blk_dec   = 1'($urandom);
            kx_valid  = 1'($urandom);
            rd_ready  = ($urandom_range(99) < pct);
            key_load  = (kl_beat >= 0) && (b == kl_beat || b == kl_beat + 2);
            if (key_load) pend = 1'b1;
            smp;
            exp_a = dec ? (NR - b) : b;
            vec++;
            if (rd_valid !== 1'b1 || rd_addr !== AW'(exp_a) || rd_last !== (b == NR) ||
                blk_ready !== 1'b0 || kx_ready !== 1'b0 || wr_en !== 1'b0 || blk_done !== 1'b0) begin
                errs++;
                $display("FAIL beat b=%0d got rv=%b addr=%0d last=%b br=%b kr=%b we=%b done=%b exp 1 %0d %b 0 0 0 0",
                         b, rd_valid, rd_addr, rd_last, blk_ready, kx_ready, wr_en, blk_done,
                         exp_a, (b == NR));
            end
            if (rd_ready) b++;
        end
        if (budget == 0) begin
            vec++;
            errs++;
            $display("FAIL block_timeout got %0d beats exp %0d", b, NR + 1);
        end
        step;
        blk_start = 1'b0;
        key_load  = 1'b0;
        kx_valid  = 1'b0;
        rd_ready  = 1'b0;
        smp;
        vec++;
        if (rd_valid !== 1'b0 || blk_done !== 1'b1 || kx_start !== pend ||
            blk_ready !== !pend || keys_valid !== !pend) begin
            errs++;
            $display("FAIL blk_end got rv=%b done=%b start=%b br=%b kv=%b exp 0 1 %b %b %b",
                     rd_valid, blk_done, kx_start, blk_ready, keys_valid, pend, !pend, !pend);
        end
        if (!pend) begin
            step;
            smp;
            vec++;
            if (blk_done !== 1'b0 || blk_ready !== 1'b1) begin
                errs++;
                $display("FAIL done_pulse got done=%b blk_ready=%b exp 0 1", blk_done, blk_ready);
            end
        end
    endtask

    task automatic test_expand_steady;
        do_expand(100, -1, 1'b0);
    endtask

    task automatic test_expand_gaps;
        do_expand(50, -1, 1'b0);
    endtask

    task automatic test_block_enc;
        do_block(1'b0, 100, -1);
    endtask

    task automatic test_block_dec_stall;
        do_block(1'b1, 50, -1);
    endtask

    task automatic test_reload;
        do_block(1'b0, 70, 4);
        do_expand(60, -1, 1'b1);
        do_expand(100, 5, 1'b0);
    endtask

    task automatic test_back_to_back;
        do_block(1'b0, 80, -1);
        do_block(1'b1, 80, -1);
        do_block(1'($urandom), 60, -1);
    endtask

    task automatic test_collision;
        step;
        key_load  = 1'b1;
        blk_start = 1'b1;
        blk_dec   = 1'b0;
        smp;
        vec++;
        if (blk_ready !== 1'b0) begin
            errs++;
            $display("FAIL collide_ready got %b exp 0", blk_ready);
        end
        step;
        key_load  = 1'b0;
        blk_start = 1'b0;
        smp;
        vec++;
        if (kx_start !== 1'b1 || rd_valid !== 1'b0 || keys_valid !== 1'b0) begin
            errs++;
            $display("FAIL collide_kick got start=%b rv=%b kv=%b exp 1 0 0",
                     kx_start, rd_valid, keys_valid);
        end
        do_expand(100, -1, 1'b1);
    endtask

    task automatic test_async_reset;
        step;
        blk_start = 1'b1;
        blk_dec   = 1'b0;
        smp;
        repeat (3) begin
            step;
            blk_start = 1'b0;
            rd_ready  = 1'b1;
            smp;
        end
        vec++;
        if (rd_valid !== 1'b1 || rd_addr !== AW'(2)) begin
            errs++;
            $display("FAIL pre_reset_run got rv=%b addr=%0d exp 1 2", rd_valid, rd_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if (all_out !== 16'h0) begin
            errs++;
            $display("FAIL async_reset got %h exp 0000", all_out);
        end
        step;
        rd_ready = 1'b0;
        rst_n = 1'b1;
        smp;
        vec++;
        if (all_out !== 16'h0) begin
            errs++;
            $display("FAIL post_reset_idle got %h exp 0000", all_out);
        end
        do_expand(100, -1, 1'b0);
        do_block(1'b1, 100, -1);
    endtask

    initial begin
        test_reset();
        test_expand_steady();
        test_block_enc();
        test_expand_gaps();
        test_block_dec_stall();
        test_reload();
        test_back_to_back();
        test_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
